// File: rtl/operand_b_pipe.sv
// operand_b_pipe: picks the ALU B operand from one of several sources and
// holds it in a 2-entry skid buffer. The buffer has valid/ready handshakes
// on both sides. Source 111 replays the value chosen at the most recent accept.
module operand_b_pipe #(
    parameter int W     = 8,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     B,
    input  logic [IMM_W-1:0] Im,
    input  logic [W-1:0]     dataDM,
    input  logic [W-1:0]     fwd,
    input  logic [2:0]       s,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       count
);

    logic [W-1:0] entry0_q, entry0_d;
    logic [W-1:0] entry1_q, entry1_d;
    logic [W-1:0] last_q, last_d;
    logic [1:0]   count_q, count_d;

    logic [W-1:0] imm_zext;
    logic [W-1:0] imm_sext;
    logic [W-1:0] sel;
    logic         accept;
    logic         pop;

    // Widen the immediate both ways. Writing the low IMM_W bits over a
    // filled background stays legal when IMM_W equals W.
    always_comb begin
        imm_zext              = '0;
        imm_zext[IMM_W-1:0]   = Im;
        imm_sext              = {W{Im[IMM_W-1]}};
        imm_sext[IMM_W-1:0]   = Im;
    end

    // Source multiplexer. Codes 000-011 keep the old 2-bit selector's meaning.
    always_comb begin
        sel = B;
        case (s)
            3'b000:  sel = B;
            3'b001:  sel = imm_zext;
            3'b010:  sel = '0;
            3'b011:  sel = dataDM;
            3'b100:  sel = imm_sext;
            3'b101:  sel = '1;
            3'b110:  sel = fwd;
            default: sel = last_q;
        endcase
    end

    // Handshake decode. Flush blocks the accept and also cancels any pop in the same cycle.
    always_comb begin
        in_ready  = (count_q != 2'd2) && !flush;
        out_valid = (count_q != 2'd0);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready && !flush;
        out_data  = entry0_q;
        count     = count_q;
    end

    // Next-state for the skid buffer. Flush only empties the buffer;
    // the stored words stay in place.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        last_d   = accept ? sel : last_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        entry0_d = sel;
                        count_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && !pop) begin
                        entry1_d = sel;
                        count_d  = 2'd2;
                    end else if (pop && !accept) begin
                        count_d  = 2'd0;
                    end else if (accept && pop) begin
                        entry0_d = sel;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        entry0_d = entry1_q;
                        count_d  = 2'd1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // State registers. Reset clears every stored word, so a later 111 replays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            last_q   <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            last_q   <= last_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_operand_b_pipe.sv
// Directed bench for operand_b_pipe with W=8 and IMM_W=4. Each step drives the
// inputs. After the next rising edge, the bench compares outputs with values
// worked out by hand.
module tb_operand_b_pipe;

    logic       clk;
    logic       reset;
    logic [7:0] B;
    logic [3:0] Im;
    logic [7:0] dataDM;
    logic [7:0] fwd;
    logic [2:0] s;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int checks;
    int errors;

    operand_b_pipe #(.W(8), .IMM_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .B         (B),
        .Im        (Im),
        .dataDM    (dataDM),
        .fwd       (fwd),
        .s         (s),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [2:0] sel,
                                 input logic [7:0] b, input logic [3:0] im,
                                 input logic [7:0] dm, input logic [7:0] fw,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        s         = sel;
        B         = b;
        Im        = im;
        dataDM    = dm;
        fwd       = fw;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

        // Accept 3C, then 0A (zero-extended), then FA (sign-extended), one per cycle.
        applyStimulus(1'b1, 3'b000, 8'h3C, 4'h5, 8'hEE, 8'hDD, 1'b1, 1'b0);
        tick();
        checkOutput("seq_b_data", 32'(out_data), 32'h3C);
        checkOutput("seq_b_valid", 32'(out_valid), 32'h1);
        applyStimulus(1'b1, 3'b001, 8'h3C, 4'hA, 8'hEE, 8'hDD, 1'b1, 1'b0);
        tick();
        checkOutput("seq_zext_data", 32'(out_data), 32'h0A);
        checkOutput("seq_zext_count", 32'(count), 32'h1);
        applyStimulus(1'b1, 3'b100, 8'h3C, 4'hA, 8'hEE, 8'hDD, 1'b1, 1'b0);
        tick();
        checkOutput("seq_sext_data", 32'(out_data), 32'hFA);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("seq_drain_count", 32'(count), 32'h0);
        checkOutput("seq_drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: fill both entries, try a third, then drain.
        applyStimulus(1'b1, 3'b011, 8'h01, 4'h2, 8'h55, 8'h03, 1'b0, 1'b0);
        tick();
        checkOutput("bp_first_data", 32'(out_data), 32'h55);
        applyStimulus(1'b1, 3'b110, 8'h01, 4'h2, 8'h04, 8'hA7, 1'b0, 1'b0);
        tick();
        checkOutput("bp_full_count", 32'(count), 32'h2);
        applyStimulus(1'b1, 3'b000, 8'h11, 4'h2, 8'h04, 8'h05, 1'b0, 1'b0);
        #1;
        checkOutput("bp_full_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkOutput("bp_third_count", 32'(count), 32'h2);
        checkOutput("bp_hold_data", 32'(out_data), 32'h55);
        applyStimulus(1'b0, 3'b000, 8'h11, 4'h2, 8'h04, 8'h05, 1'b1, 1'b0);
        tick();
        checkOutput("bp_pop1_data", 32'(out_data), 32'hA7);
        checkOutput("bp_pop1_count", 32'(count), 32'h1);
        checkOutput("bp_pop1_in_ready", 32'(in_ready), 32'h1);
        tick();
        checkOutput("bp_pop2_count", 32'(count), 32'h0);

        // Accept and pop together while count is 1, using all-ones.
        applyStimulus(1'b1, 3'b000, 8'h12, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("ap_pre_data", 32'(out_data), 32'h12);
        applyStimulus(1'b1, 3'b101, 8'h12, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("ap_count", 32'(count), 32'h1);
        checkOutput("ap_ones_data", 32'(out_data), 32'hFF);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("ap_drain_count", 32'(count), 32'h0);

        // Repeat mode. fwd changes during the 111 steps, so they must replay 81 and ignore fwd.
        applyStimulus(1'b1, 3'b110, 8'h00, 4'h0, 8'h00, 8'h81, 1'b1, 1'b0);
        tick();
        checkOutput("rep_fwd_data", 32'(out_data), 32'h81);
        applyStimulus(1'b1, 3'b111, 8'h00, 4'h0, 8'h00, 8'h5A, 1'b1, 1'b0);
        tick();
        checkOutput("rep_1_data", 32'(out_data), 32'h81);
        tick();
        checkOutput("rep_2_data", 32'(out_data), 32'h81);
        checkOutput("rep_2_count", 32'(count), 32'h1);
        applyStimulus(1'b1, 3'b010, 8'h77, 4'hF, 8'h77, 8'h77, 1'b1, 1'b0);
        tick();
        checkOutput("rep_zero_data", 32'(out_data), 32'h00);
        applyStimulus(1'b1, 3'b111, 8'h77, 4'hF, 8'h77, 8'h77, 1'b1, 1'b0);
        tick();
        checkOutput("rep_after_zero", 32'(out_data), 32'h00);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("rep_drain_count", 32'(count), 32'h0);

        // Flush while full, with in_valid and out_ready also high.
        applyStimulus(1'b1, 3'b000, 8'h21, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'b000, 8'h22, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("fl_pre_count", 32'(count), 32'h2);
        applyStimulus(1'b1, 3'b000, 8'h33, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1);
        #1;
        checkOutput("fl_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkOutput("fl_count", 32'(count), 32'h0);
        checkOutput("fl_out_valid", 32'(out_valid), 32'h0);
        checkOutput("fl_entry0_kept", 32'(out_data), 32'h21);
        applyStimulus(1'b1, 3'b111, 8'h44, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("fl_replay_data", 32'(out_data), 32'h22);
        checkOutput("fl_replay_count", 32'(count), 32'h1);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
        tick();

        // Assert reset between edges while the buffer is full.
        applyStimulus(1'b1, 3'b001, 8'h00, 4'h7, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 3'b101, 8'h00, 4'h7, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("ar_pre_count", 32'(count), 32'h2);
        checkOutput("ar_pre_data", 32'(out_data), 32'h07);
        applyStimulus(1'b0, 3'b000, 8'h00, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_out_valid", 32'(out_valid), 32'h0);
        checkOutput("ar_count", 32'(count), 32'h0);
        checkOutput("ar_out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 3'b111, 8'h99, 4'h9, 8'h99, 8'h99, 1'b1, 1'b0);
        tick();
        checkOutput("ar_replay_data", 32'(out_data), 32'h00);
        checkOutput("ar_replay_count", 32'(count), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
